// File: rtl/sar_sequencer.sv
// Successive-approximation sequencer: clears the bit slices, then walks MSB to LSB
// driving trial codes to the DAC, pulsing one slice enable per decision.
module sar_sequencer #(
   parameter int NBITS  = 8,
   parameter int SETTLE = 2
) (
   input  logic             CLK,
   input  logic             VRESETB,
   input  logic             VSTART,
   input  logic             VCOMP,
   output logic             VSLICE_RST,
   output logic [NBITS-1:0] VENABLE,
   output logic [NBITS-1:0] VDAC,
   output logic [NBITS-1:0] DOUT,
   output logic             VBUSY,
   output logic             VDONE
);

   localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [IW-1:0]    IDX_MSB_C     = IW'(NBITS - 1);
   localparam logic [IW-1:0]    IDX_ONE_C     = IW'(1);
   localparam logic [IW-1:0]    IDX_ZERO_C    = IW'(0);
   localparam logic [3:0]       SETTLE_LAST_C = 4'(SETTLE - 1);
   localparam logic [NBITS-1:0] ONE_C         = {{(NBITS-1){1'b0}}, 1'b1};
   localparam logic [NBITS-1:0] ZERO_C        = {NBITS{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_TRIAL  = 3'd2,
      S_DECIDE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [IW-1:0]    idx_r, idx_nxt_s;
   logic [3:0]       cnt_r, cnt_nxt_s;
   logic [NBITS-1:0] acc_r, acc_nxt_s;

   logic             slice_rst_r, slice_rst_nxt_s;
   logic [NBITS-1:0] enable_r, enable_nxt_s;
   logic [NBITS-1:0] dac_r, dac_nxt_s;
   logic [NBITS-1:0] dout_r, dout_nxt_s;
   logic             busy_r, busy_nxt_s;
   logic             done_r, done_nxt_s;

   // State and datapath registers
   always_ff @(posedge CLK or negedge VRESETB) begin
      if (!VRESETB) begin
         state_r <= S_IDLE;
         idx_r   <= IDX_ZERO_C;
         cnt_r   <= 4'd0;
         acc_r   <= ZERO_C;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         cnt_r   <= cnt_nxt_s;
         acc_r   <= acc_nxt_s;
      end
   end

   // Next-state decode; unknown encodings fall back to IDLE
   always_comb begin
      state_nxt_s = S_IDLE;
      case (state_r)
         S_IDLE: begin
            if (VSTART) state_nxt_s = S_CLEAR;
            else        state_nxt_s = S_IDLE;
         end
         S_CLEAR: state_nxt_s = S_TRIAL;
         S_TRIAL: begin
            if (cnt_r == SETTLE_LAST_C) state_nxt_s = S_DECIDE;
            else                        state_nxt_s = S_TRIAL;
         end
         S_DECIDE: begin
            if (idx_r == IDX_ZERO_C) state_nxt_s = S_DONE;
            else                     state_nxt_s = S_TRIAL;
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Bit index, settle counter and working code; VCOMP only matters in DECIDE
   always_comb begin
      acc_nxt_s = acc_r;
      idx_nxt_s = idx_r;
      cnt_nxt_s = cnt_r;
      case (state_r)
         S_CLEAR: begin
            acc_nxt_s = ZERO_C;
            idx_nxt_s = IDX_MSB_C;
            cnt_nxt_s = 4'd0;
         end
         S_TRIAL: cnt_nxt_s = cnt_r + 4'd1;
         S_DECIDE: begin
            acc_nxt_s[idx_r] = VCOMP;
            if (idx_r != IDX_ZERO_C) begin
               idx_nxt_s = idx_r - IDX_ONE_C;
               cnt_nxt_s = 4'd0;
            end else begin
               idx_nxt_s = idx_r;
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            acc_nxt_s = acc_r;
         end
      endcase
   end

   // Moore outputs computed from the state being entered, then registered
   always_comb begin
      slice_rst_nxt_s = 1'b0;
      enable_nxt_s    = ZERO_C;
      dac_nxt_s       = acc_nxt_s;
      dout_nxt_s      = dout_r;
      busy_nxt_s      = 1'b0;
      done_nxt_s      = 1'b0;
      case (state_nxt_s)
         S_IDLE: dac_nxt_s = acc_nxt_s;
         S_CLEAR: begin
            slice_rst_nxt_s = 1'b1;
            busy_nxt_s      = 1'b1;
         end
         S_TRIAL: begin
            busy_nxt_s = 1'b1;
            dac_nxt_s  = acc_nxt_s | (ONE_C << idx_nxt_s);
         end
         S_DECIDE: begin
            busy_nxt_s   = 1'b1;
            dac_nxt_s    = acc_nxt_s | (ONE_C << idx_nxt_s);
            enable_nxt_s = ONE_C << idx_nxt_s;
         end
         S_DONE: begin
            done_nxt_s = 1'b1;
            dout_nxt_s = acc_nxt_s;
         end
         default: dac_nxt_s = acc_nxt_s;
      endcase
   end

   // Output registers; slices stay in reset while VRESETB is low
   always_ff @(posedge CLK or negedge VRESETB) begin
      if (!VRESETB) begin
         slice_rst_r <= 1'b1;
         enable_r    <= ZERO_C;
         dac_r       <= ZERO_C;
         dout_r      <= ZERO_C;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         slice_rst_r <= slice_rst_nxt_s;
         enable_r    <= enable_nxt_s;
         dac_r       <= dac_nxt_s;
         dout_r      <= dout_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
      end
   end

   assign VSLICE_RST = slice_rst_r;
   assign VENABLE    = enable_r;
   assign VDAC       = dac_r;
   assign DOUT       = dout_r;
   assign VBUSY      = busy_r;
   assign VDONE      = done_r;

endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: ideal comparator around the DUT, trial codes and
// results predicted from the input level X.
module tb_sar_sequencer;

   logic       CLK = 1'b0;
   logic       VRESETB, VSTART, VCOMP;
   logic       VSLICE_RST, VBUSY, VDONE;
   logic [7:0] VENABLE, VDAC, DOUT;

   logic       start4;
   logic       comp4, slice4, busy4, done4;
   logic [3:0] venable4, vdac4, dout4;
   logic [3:0] x4 = 4'h9;

   logic [7:0] x_val     = 8'h00;
   bit         noise_en  = 1'b0;
   bit         noise_bit = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   // Ideal comparator; outside DECIDE it may be replaced by random noise
   assign VCOMP = (noise_en && VENABLE == 8'h00) ? noise_bit : (x_val >= VDAC);
   assign comp4 = (x4 >= vdac4);

   sar_sequencer #(.NBITS(8), .SETTLE(2)) u_dut (
      .CLK(CLK), .VRESETB(VRESETB), .VSTART(VSTART), .VCOMP(VCOMP),
      .VSLICE_RST(VSLICE_RST), .VENABLE(VENABLE), .VDAC(VDAC), .DOUT(DOUT),
      .VBUSY(VBUSY), .VDONE(VDONE)
   );

   sar_sequencer #(.NBITS(4), .SETTLE(1)) u_dut4 (
      .CLK(CLK), .VRESETB(VRESETB), .VSTART(start4), .VCOMP(comp4),
      .VSLICE_RST(slice4), .VENABLE(venable4), .VDAC(vdac4), .DOUT(dout4),
      .VBUSY(busy4), .VDONE(done4)
   );

   typedef struct {
      logic [7:0] x;
      bit         noise;
      bit         pulse_mid;
      logic [7:0] exp_dout;
      int         exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Ideal SAR: bits above the trial bit already equal X, trial bit set
   function automatic logic [7:0] trial_code(input logic [7:0] x, input int k);
      logic [7:0] m;
      logic [7:0] one;
      m   = 8'hFF;
      m   = m << (8 - k);
      one = 8'h01;
      return (x & m) | (one << (7 - k));
   endfunction

   task automatic run_conv(input logic [7:0] x, input bit noise, input bit pulse_mid,
                           input logic [7:0] exp_dout, input int exp_lat);
      int c, k, done_c, busy_cnt;
      bit bad, busy_after;
      logic [7:0] one;
      one      = 8'h01;
      x_val    = x;
      noise_en = noise;
      @(negedge CLK);
      VSTART = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      VSTART   = 1'b0;
      c        = 1;
      k        = 0;
      done_c   = -1;
      busy_cnt = 0;
      bad      = 1'b0;
      chk("clear_slice_rst", 32'(VSLICE_RST), 32'd1);
      chk("clear_busy", 32'(VBUSY), 32'd1);
      while (c < 200 && done_c < 0) begin
         noise_bit = 1'($urandom_range(0, 1));
         VSTART    = (pulse_mid && c == 10) ? 1'b1 : 1'b0;
         if ($countones(VENABLE) > 1) bad = 1'b1;
         if (VBUSY) busy_cnt++;
         if (VENABLE != 8'h00) begin
            if (k < 8) begin
               chk("venable", 32'(VENABLE), 32'(one << (7 - k)));
               chk("vdac", 32'(VDAC), 32'(trial_code(x, k)));
            end
            k++;
         end
         if (VDONE) done_c = c;
         else begin
            @(negedge CLK);
            c++;
         end
      end
      VSTART = 1'b0;
      chk("done_cycle", 32'(done_c), 32'(exp_lat));
      chk("dout", 32'(DOUT), 32'(exp_dout));
      chk("decide_count", 32'(k), 32'd8);
      chk("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
      chk("onehot", 32'(bad), 32'd0);
      chk("busy_in_done", 32'(VBUSY), 32'd0);
      busy_after = 1'b0;
      repeat (pulse_mid ? 30 : 2) begin
         @(negedge CLK);
         if (VBUSY) busy_after = 1'b1;
      end
      chk("no_queued_start", 32'(busy_after), 32'd0);
      chk("dout_stable", 32'(DOUT), 32'(exp_dout));
      noise_en = 1'b0;
   endtask

   int         c, d4;
   logic [3:0] q4[$];
   logic [3:0] exp4[4];
   int         dones[$];
   int         slices[$];
   bit         seen_done;
   logic [7:0] rx;

   initial begin
      VRESETB = 1'b0;
      VSTART  = 1'b0;
      start4  = 1'b0;
      vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 26};
      vecs[1] = '{8'h00, 1'b0, 1'b0, 8'h00, 26};
      vecs[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 26};
      vecs[3] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 26};
      vecs[4] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 26};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 26};
      vecs[6] = '{8'h7F, 1'b0, 1'b1, 8'h7F, 26};
      vecs[7] = '{8'h01, 1'b1, 1'b0, 8'h01, 26};
      exp4    = '{4'h8, 4'hC, 4'hA, 4'h9};

      #12;
      chk("rst_slice_rst", 32'(VSLICE_RST), 32'd1);
      chk("rst_venable", 32'(VENABLE), 32'd0);
      chk("rst_vdac", 32'(VDAC), 32'd0);
      chk("rst_dout", 32'(DOUT), 32'd0);
      chk("rst_busy", 32'(VBUSY), 32'd0);
      chk("rst_done", 32'(VDONE), 32'd0);
      @(negedge CLK);
      VRESETB = 1'b1;
      @(negedge CLK);
      chk("idle_slice_rst", 32'(VSLICE_RST), 32'd0);

      // Narrow instance: NBITS=4, SETTLE=1
      @(negedge CLK);
      start4 = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      start4 = 1'b0;
      c      = 1;
      d4     = -1;
      while (c < 60 && d4 < 0) begin
         if (venable4 != 4'h0) q4.push_back(vdac4);
         if (done4) d4 = c;
         else begin
            @(negedge CLK);
            c++;
         end
      end
      chk("n4_done_cycle", 32'(d4), 32'd10);
      chk("n4_dout", 32'(dout4), 32'h9);
      chk("n4_trials", 32'(q4.size()), 32'd4);
      for (int i = 0; i < q4.size() && i < 4; i++) chk("n4_vdac", 32'(q4[i]), 32'(exp4[i]));

      for (int i = 0; i < 8; i++)
         run_conv(vecs[i].x, vecs[i].noise, vecs[i].pulse_mid, vecs[i].exp_dout, vecs[i].exp_lat);

      for (int i = 0; i < 6; i++) begin
         rx = 8'($urandom_range(0, 255));
         run_conv(rx, 1'b1, 1'b0, rx, 26);
      end

      // VSTART held high: a conversion every 27 cycles
      x_val = 8'h5A;
      @(negedge CLK);
      VSTART = 1'b1;
      @(posedge CLK);
      for (int cc = 1; cc <= 85; cc++) begin
         @(negedge CLK);
         if (VDONE) begin
            dones.push_back(cc);
            chk("held_dout", 32'(DOUT), 32'h5A);
         end
         if (VSLICE_RST) slices.push_back(cc);
      end
      VSTART = 1'b0;
      chk("held_done_count", 32'(dones.size()), 32'd3);
      chk("held_slice_count", 32'(slices.size()), 32'd4);
      for (int i = 0; i < dones.size() && i < 3; i++) chk("held_done_cycle", 32'(dones[i]), 32'(26 + 27 * i));
      for (int i = 0; i < slices.size() && i < 4; i++) chk("held_slice_cycle", 32'(slices[i]), 32'(1 + 27 * i));
      repeat (40) @(negedge CLK);
      chk("held_idle", 32'(VBUSY), 32'd0);

      // Reset during bit 3's TRIAL
      x_val = 8'hA5;
      @(negedge CLK);
      VSTART = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      VSTART = 1'b0;
      repeat (11) @(negedge CLK);
      chk("b3_trial_vdac", 32'(VDAC), 32'hB0);
      chk("b3_busy", 32'(VBUSY), 32'd1);
      #2 VRESETB = 1'b0;
      #1;
      chk("mid_rst_dout", 32'(DOUT), 32'd0);
      chk("mid_rst_venable", 32'(VENABLE), 32'd0);
      chk("mid_rst_busy", 32'(VBUSY), 32'd0);
      chk("mid_rst_vdac", 32'(VDAC), 32'd0);
      chk("mid_rst_slice_rst", 32'(VSLICE_RST), 32'd1);
      @(negedge CLK);
      VRESETB   = 1'b1;
      seen_done = 1'b0;
      repeat (30) begin
         @(negedge CLK);
         if (VDONE || VBUSY) seen_done = 1'b1;
      end
      chk("mid_rst_no_done", 32'(seen_done), 32'd0);
      run_conv(8'h3C, 1'b0, 1'b0, 8'h3C, 26);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
